bcd_seq_converter: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") for the seven-segment display driver path.
- Processes one binary bit per clock, so a single set of per-digit add-3 correction stages handles the whole word.
- Start/busy/done handshake on the input side; registered packed BCD digits on the output, held stable for the digit-scan logic.

---
 rtl/bcd_seq_converter_if.sv | 16 +
 rtl/bcd_seq_converter.sv | 107 ++++++++++
 tb/tb_bcd_seq_converter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_converter_if.sv
// Start/busy/done handshake and result bus for the sequential binary-to-BCD converter.
// master = requester (display path), slave = converter.
interface bcd_seq_converter_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble converter: one binary bit per clock through a shared
// row of per-digit add-3 lanes; saturates to all nines when the input overflows.
module bcd_dabble_lane (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    logic [3:0] corr;

    // corrected digit shifts left one; its MSB carries into the next digit
    assign corr = (d >= 4'd5) ? d + 4'd3 : d;
    assign q    = {corr[2:0], cin};
    assign cout = corr[3];
endmodule

module bcd_seq_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_seq_converter_if.slave   io
);
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] MAXV  = 32'(10**DIGITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    state;
    logic [BIN_W-1:0]          shreg;
    logic [DIGITS-1:0][3:0]    wbcd;
    logic [DIGITS-1:0][3:0]    wbcd_nx;
    logic [DIGITS:0]           carry;
    logic [CNT_W-1:0]          cnt;
    logic                      ovf_p;
    logic                      top_c;
    logic                      busy_q;
    logic                      done_q;
    logic                      ovf_q;
    logic [4*DIGITS-1:0]       bcd_q;
    logic                      sat;

    assign carry[0] = shreg[BIN_W-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        bcd_dabble_lane u_lane (
            .d    (wbcd[g]),
            .cin  (carry[g]),
            .q    (wbcd_nx[g]),
            .cout (carry[g+1])
        );
    end

    // a carry out of the top digit can only happen on an overflowed input,
    // so folding it in just reinforces the saturation decision
    assign sat = ovf_p | top_c | carry[DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            wbcd   <= '0;
            cnt    <= '0;
            ovf_p  <= 1'b0;
            top_c  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            bcd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        shreg  <= io.bin;
                        wbcd   <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        ovf_p  <= (32'(io.bin) > MAXV);
                        top_c  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    wbcd  <= wbcd_nx;
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    top_c <= top_c | carry[DIGITS];
                    if (cnt == CNT_W'(1)) begin
                        bcd_q  <= sat ? {DIGITS{4'h9}} : wbcd_nx;
                        ovf_q  <= ovf_p;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
    assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed plus random bench for bcd_seq_converter (BIN_W=14, DIGITS=4) against
// a decimal-arithmetic reference model.
module tb_bcd_seq_converter;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bcd_seq_converter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // working digits must stay decimal before correction
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < DIGITS; d++)
                chk("digit_le9", {31'b0, (dut.wbcd[d] <= 4'd9)}, 32'd1);
        end
    end

    // one conversion; ign_at>0 injects a one-cycle start (bin=777) at that busy cycle
    task automatic conv(input int v, input int ign_at, input string tag);
        int cyc;
        int busy_n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'(v);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 14'($urandom_range(0, 16383));
        cyc = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            if (ign_at > 0 && cyc == ign_at) begin
                bus.start = 1'b1;
                bus.bin   = 14'd777;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), 32'd14);
        chk({tag, "_busycyc"}, 32'(busy_n), 32'd14);
        chk({tag, "_bcd"}, {16'b0, bus.bcd}, {16'b0, ref_bcd(v)});
        chk({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, (v > 9999)});
        chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_bcd_hold"}, {16'b0, bus.bcd}, {16'b0, ref_bcd(v)});
    endtask

    initial begin
        int cyc;
        int vals[3];
        int ndone;
        bus.start = 1'b0;
        bus.bin   = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_bcd", {16'b0, bus.bcd}, 32'd0);
        chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        rst_n = 1'b1;

        // directed values and correction boundaries
        conv(0, 0, "zero");
        conv(1234, 0, "v1234");
        conv(9999, 0, "v9999");
        conv(5, 0, "v5");
        conv(9, 0, "v9");
        conv(10000, 0, "v10000");
        conv(16383, 0, "v16383");
        conv(42, 0, "v42");

        // start during busy is dropped
        conv(321, 5, "ign");

        // start held high: each result accepted on the done edge, no idle gap
        vals = '{100, 200, 300};
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'(vals[0]);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_busy_start", {31'b0, bus.busy}, 32'd1);
            cyc = 0;
            while (bus.done !== 1'b1 && cyc < 40) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            chk("b2b_lat", 32'(cyc), 32'd14);
            chk("b2b_bcd", {16'b0, bus.bcd}, {16'b0, ref_bcd(vals[k])});
            if (k < 2) bus.bin = 14'(vals[k+1]);
            else       bus.start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("b2b_idle_after", {31'b0, bus.busy}, 32'd0);

        // asynchronous reset mid-conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd4321;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_bcd", {16'b0, bus.bcd}, 32'd0);
        chk("arst_ovf", {31'b0, bus.ovf}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        chk("arst_bcd_held", {16'b0, bus.bcd}, 32'd0);
        conv(55, 0, "post_rst");

        // random sweep
        for (int i = 0; i < 40; i++)
            conv(int'($urandom_range(0, 16383)), 0, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
